spmv_csr_loader: RTL
====================

# spmv_csr_loader

Upstream fill stage for the SpMV engine. Accepts the host's 16-bit word stream and packs it into 256-bit lines. Writes each line into SRAM A (input vector and matrix values) or SRAM B (row pointers and column indices) at consecutive addresses. Emits a one-cycle `o_done` pulse that the top level routes to the SpMV sequencer's start input once both memories are loaded.

## Interface
Parameters:
- DATA_W, 16, width of one stream word / one matrix element
- LINE_W, 256, SRAM line width; LANES = LINE_W/DATA_W = 16
- ADDR_W, 5, SRAM address width (32 lines)

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_load_start  in  1  pulse; latches descriptor, begins a load
- i_target  in  1  0 = SRAM A, 1 = SRAM B; sampled with i_load_start
- i_base_addr  in  ADDR_W  first line address; sampled with i_load_start
- i_num_lines  in  ADDR_W+1  lines to write, 0..32; sampled with i_load_start
- i_valid  in  1  stream word valid
- i_data  in  DATA_W  stream word
- o_ready  out  1  stream ready; word accepted when i_valid && o_ready
- o_wr_en_A  out  1  SRAM A write strobe
- o_wr_en_B  out  1  SRAM B write strobe
- o_address_A  out  ADDR_W  SRAM A address
- o_address_B  out  ADDR_W  SRAM B address
- o_write_data  out  LINE_W  packed line
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle completion pulse
- o_checksum  out  DATA_W  XOR of accepted words (see Configuration)

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - If i_load_start is high, latch the descriptor, clear the lane counter, line counter, pack register and checksum.
  - If i_num_lines == 0, go to DONE; otherwise go to FILL.
- FILL:
  - o_ready = 1.
  - Each accepted word is stored in lane `lane_cnt`, bits [16*lane_cnt +: 16]. Lane 0 is the first word of the line (little-endian lane order, matching the SpMV read-side decoders).
  - Acceptance of the word for lane 15 moves the FSM to WRITE.
- WRITE (exactly one cycle):
  - o_ready = 0.
  - The selected o_wr_en_* is high; the other stays low.
  - Both o_address_* = base + line_cnt, mod 32; addresses wrap 31 -> 0.
  - o_write_data holds the packed line.
  - line_cnt increments. If the new value equals num_lines, go to DONE; otherwise go to FILL with lane_cnt = 0.
- DONE: o_done = 1 for one cycle, then IDLE.
- i_load_start outside IDLE is ignored.
- i_valid outside FILL is ignored; no word is consumed.
- o_ready is decoded from registered state only, with no combinational path from i_valid.
- o_address_* and o_write_data are registered and hold their last value outside WRITE. Consumers qualify them with wr_en.

## Timing
- Reset value of every output is 0, including o_write_data, addresses and o_checksum. FSM resets to IDLE.
- Reset mid-load:
  - Any partial line is discarded and no write is issued.
  - i_rst has priority over all other inputs in the same cycle.
- Descriptor to ready: i_load_start at cycle t gives o_ready = 1 at t+1.
- Write latency: the 16th word of a line is accepted at cycle c; wr_en is high at c+1 and o_ready is low at c+1.
- Throughput: 17 cycles per line with continuous i_valid.
- Completion: the last write at cycle w gives o_done at w+1 and IDLE at w+2. A new i_load_start is accepted from w+2.
- num_lines == 0: o_done at t+1 and no write.
- Stalls (i_valid low) in FILL hold all counters. There is no timeout.

## Configuration
- SPMV_LOADER_CHKSUM_EN:
  - Defined: o_checksum is a register cleared on i_load_start and XORed with every accepted word. It is valid from the o_done cycle and held until the next i_load_start.
  - Undefined: no checksum logic is built and o_checksum is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package spmv_pkg holds:
  - DATA_W, LINE_W, ADDR_W and LANES constants
  - loader state enum (IDLE/FILL/WRITE/DONE)
  - target enum (TGT_A = 0, TGT_B = 1)
- Sub-module spmv_line_packer holds the lane counter, 256-bit pack register and a "line full" flag.
- The loader top holds the FSM, descriptor registers, address generation and the write strobe.

## Test plan
- Single line, A: load_start(target=0, base=3, num=1), words 0x0001..0x0010 back-to-back -> one wr_en_A at cycle c+1, address_A=3, write_data[15:0]=0x0001, [255:240]=0x0010; wr_en_B never high; o_done one cycle later.
- Wrap, B: target=1, base=30, num=4, 64 words -> four wr_en_B at addresses 30, 31, 0, 1, each exactly 17 cycles apart; o_ready low on each write cycle.
- Backpressure/stall: i_valid toggled every other cycle during one line -> data packed correctly with no lost or duplicated lanes; the write occurs one cycle after the 16th accepted word.
- Zero lines and ignored start: num=0 -> o_done at t+1 with no writes; a second i_load_start while in FILL -> descriptor unchanged and line count unaffected.
- Reset mid-line: assert i_rst after 7 words -> no write and all outputs 0 next cycle. A fresh 1-line load then writes only the new 16 words.
- Checksum (with SPMV_LOADER_CHKSUM_EN): 16 words 0x00FF,0xFF00 repeating -> o_checksum = 0x0000 at o_done. With words 1..16 -> o_checksum = 0x0010. Macro undefined -> o_checksum stays 0.

Source files
------------

// File: rtl/spmv_pkg.sv
// spmv_pkg: shared widths, loader FSM states and SRAM target encoding
// for the SpMV fill path.
package spmv_pkg;
   localparam int DATA_W  = 16;
   localparam int LINE_W  = 256;
   localparam int ADDR_W  = 5;
   localparam int LANES   = LINE_W / DATA_W;
   localparam int LANE_W  = $clog2(LANES);
   localparam int DATA_SH = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   typedef enum logic {
      TGT_A = 1'b0,
      TGT_B = 1'b1
   } target_t;
endpackage

// File: rtl/spmv_csr_loader_if.sv
// spmv_csr_loader_if: host word stream into the CSR loader, plus the
// loader FSM state for observation.
// Handshake: a word transfers on the rising edge where i_valid && o_ready;
// o_ready comes from registered state only and never depends on i_valid;
// i_data is only meaningful while i_valid is high.
interface spmv_csr_loader_if;
   import spmv_pkg::*;

   logic                 i_valid;
   logic [DATA_W-1:0]    i_data;
   logic                 o_ready;
   loader_state_t        dbg_state;

   modport master (output i_valid, output i_data, input o_ready, input dbg_state);
   modport slave  (input i_valid, input i_data, output o_ready, output dbg_state);
endinterface

// File: rtl/spmv_line_packer.sv
// spmv_line_packer: gathers 16-bit words into a 256-bit line, lane 0 first
// (little-endian lane order). o_line_next is the line including the word
// currently offered, so the caller can capture a complete line on the same
// edge that accepts the last lane.
module spmv_line_packer
   import spmv_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [DATA_W-1:0] i_data,
   output logic [LINE_W-1:0] o_line_next,
   output logic              o_last_lane,
   output logic              o_line_full
);
   logic [LANE_W-1:0]          r_lane_cnt;
   logic [LINE_W-1:0]          r_pack;
   logic                       r_line_full;
   logic [LANE_W+DATA_SH-1:0]  w_lsb;

   assign w_lsb       = {r_lane_cnt, DATA_SH'(0)};
   assign o_last_lane = (r_lane_cnt == LANE_W'(LANES - 1));
   assign o_line_full = r_line_full;

   // Merge the offered word into its lane of the current pack register
   always_comb begin
      o_line_next = r_pack;
      o_line_next[w_lsb +: DATA_W] = i_data;
   end

   // Lane counter, pack register and line-full flag; lane counter wraps 15 -> 0
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_lane_cnt  <= '0;
         r_pack      <= '0;
         r_line_full <= 1'b0;
      end else begin
         r_line_full <= i_accept && o_last_lane;
         if (i_accept) begin
            r_pack     <= o_line_next;
            r_lane_cnt <= r_lane_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/spmv_csr_loader.sv
// spmv_csr_loader: packs the host word stream into 256-bit lines and writes
// them to SRAM A or SRAM B at consecutive (wrapping) addresses, then pulses
// o_done. Optional feature macro: SPMV_LOADER_CHKSUM_EN builds an XOR
// checksum of accepted words on o_checksum; otherwise o_checksum is 0.
module spmv_csr_loader
   import spmv_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_start,
   input  logic              i_target,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_num_lines,
   spmv_csr_loader_if.slave  stream,
   output logic              o_wr_en_A,
   output logic              o_wr_en_B,
   output logic [ADDR_W-1:0] o_address_A,
   output logic [ADDR_W-1:0] o_address_B,
   output logic [LINE_W-1:0] o_write_data,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_checksum
);
   loader_state_t      r_state, w_next_state;
   target_t            r_target;
   logic [ADDR_W-1:0]  r_base;
   logic [ADDR_W:0]    r_num_lines;
   logic [ADDR_W:0]    r_line_cnt;
   logic [ADDR_W:0]    w_line_cnt_inc;
   logic [ADDR_W-1:0]  r_address;
   logic [LINE_W-1:0]  r_write_data;
   logic [LINE_W-1:0]  w_line_next;
   logic               w_start, w_accept, w_last_lane, w_line_full, w_ready;

   assign w_start        = (r_state == IDLE) && i_load_start;
   assign w_accept       = (r_state == FILL) && stream.i_valid;
   assign w_line_cnt_inc = r_line_cnt + 1'b1;

   spmv_line_packer u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_start),
      .i_accept    (w_accept),
      .i_data      (stream.i_data),
      .o_line_next (w_line_next),
      .o_last_lane (w_last_lane),
      .o_line_full (w_line_full)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_load_start) w_next_state = (i_num_lines == '0) ? DONE : FILL;
         FILL:    if (w_accept && w_last_lane) w_next_state = WRITE;
         WRITE:   w_next_state = (w_line_cnt_inc == r_num_lines) ? DONE : FILL;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output decode from registered state
   always_comb begin
      w_ready   = (r_state == FILL);
      o_busy    = (r_state != IDLE);
      o_done    = (r_state == DONE);
      o_wr_en_A = (r_state == WRITE) && w_line_full && (r_target == TGT_A);
      o_wr_en_B = (r_state == WRITE) && w_line_full && (r_target == TGT_B);
   end

   assign stream.o_ready     = w_ready;
   assign stream.dbg_state   = r_state;
   assign o_address_A        = r_address;
   assign o_address_B        = r_address;
   assign o_write_data       = r_write_data;

   // Descriptor latch, line counter, and write address/data capture on the last lane
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_target     <= TGT_A;
         r_base       <= '0;
         r_num_lines  <= '0;
         r_line_cnt   <= '0;
         r_address    <= '0;
         r_write_data <= '0;
      end else begin
         if (w_start) begin
            r_target    <= target_t'(i_target);
            r_base      <= i_base_addr;
            r_num_lines <= i_num_lines;
            r_line_cnt  <= '0;
         end
         if (w_accept && w_last_lane) begin
            r_address    <= r_base + r_line_cnt[ADDR_W-1:0];
            r_write_data <= w_line_next;
         end
         if (r_state == WRITE) r_line_cnt <= w_line_cnt_inc;
      end
   end

`ifdef SPMV_LOADER_CHKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   // Running XOR of accepted words, cleared when a load starts
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start) r_checksum <= '0;
      else if (w_accept)    r_checksum <= r_checksum ^ stream.i_data;
   end

   assign o_checksum = r_checksum;
`else
   assign o_checksum = '0;
`endif
endmodule
